// File: rtl/dds_pkg.sv
// Shared encodings for the dds_bank slice: waveform modes, register map, pipeline latency.
// Latency depends on DDS_BANK_SINE_LUT_EN (sine ROM adds one stage).
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SINE   = 2'd3
  } mode_e;

  localparam logic [1:0] REG_TW   = 2'd0;
  localparam logic [1:0] REG_OFF  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;

`ifdef DDS_BANK_SINE_LUT_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

endpackage

// File: rtl/dds_channel.sv
// One DDS channel: shadow/active registers, phase accumulator and waveform stage.
// DDS_BANK_SINE_LUT_EN adds a quarter-wave sine ROM stage (all modes delay-balanced).
module dds_channel #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned LUT_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_reg_i,
  input  logic [ACC_W-1:0] wr_data_i,
  input  logic             commit_i,
  input  logic             sync_i,
  output logic [OUT_W-1:0] sample_o
);
  import dds_pkg::*;

  if (OUT_W < 2 || OUT_W > ACC_W || LUT_AW < 1 || LUT_AW + 2 > ACC_W) begin : g_bad_cfg
    $error("dds_channel: unsupported ACC_W/OUT_W/LUT_AW combination");
  end

  logic [ACC_W-1:0] sh_tw_q, sh_off_q, act_tw_q, act_off_q;
  logic             sh_en_q, act_en_q;
  mode_e            sh_mode_q, act_mode_q;

  logic [ACC_W-1:0] acc_q, acc_d, off_s1_q;
  logic             en_s1_q;
  mode_e            mode_s1_q;

  logic [OUT_W-1:0] p, wave_d;

  // Non-blocking copy means a same-cycle write stays in the shadow until the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_tw_q    <= '0;
      sh_off_q   <= '0;
      sh_en_q    <= 1'b0;
      sh_mode_q  <= MODE_SAW;
      act_tw_q   <= '0;
      act_off_q  <= '0;
      act_en_q   <= 1'b0;
      act_mode_q <= MODE_SAW;
    end else begin
      if (wr_en_i) begin
        case (wr_reg_i)
          REG_TW:   sh_tw_q  <= wr_data_i;
          REG_OFF:  sh_off_q <= wr_data_i;
          REG_CTRL: begin
            sh_en_q   <= wr_data_i[CTRL_EN_BIT];
            sh_mode_q <= mode_e'(wr_data_i[CTRL_MODE_LSB +: 2]);
          end
          default: ;
        endcase
      end
      if (commit_i) begin
        act_tw_q   <= sh_tw_q;
        act_off_q  <= sh_off_q;
        act_en_q   <= sh_en_q;
        act_mode_q <= sh_mode_q;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (sync_i)        acc_d = '0;
    else if (act_en_q) acc_d = acc_q + act_tw_q;
  end

  // Offset, enable and mode travel with the accumulator so a commit lands coherently.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      off_s1_q  <= '0;
      en_s1_q   <= 1'b0;
      mode_s1_q <= MODE_SAW;
    end else begin
      acc_q     <= acc_d;
      off_s1_q  <= act_off_q;
      en_s1_q   <= act_en_q;
      mode_s1_q <= act_mode_q;
    end
  end

  assign p = OUT_W'((acc_q + off_s1_q) >> (ACC_W - OUT_W));

  always_comb begin
    wave_d = p;
    case (mode_s1_q)
      MODE_SQUARE: wave_d = {OUT_W{p[OUT_W-1]}};
      MODE_TRI:    wave_d = p[OUT_W-1] ? ~(p << 1) : (p << 1);
      default:     wave_d = p;
    endcase
    if (!en_s1_q) wave_d = '0;
  end

`ifdef DDS_BANK_SINE_LUT_EN
  function automatic logic [OUT_W-2:0] rom_entry(input int unsigned i);
    real a;
    a = (2.0 ** (OUT_W - 1) - 1.0) *
        $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / (2.0 ** LUT_AW));
    return (OUT_W-1)'($rtoi(a + 0.5));
  endfunction

  logic [OUT_W-2:0]  rom [2**LUT_AW];
  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    localparam logic [OUT_W-2:0] V = rom_entry(i);
    assign rom[i] = V;
  end

  logic [LUT_AW+1:0]  ph_top;
  logic [LUT_AW-1:0]  addr_q;
  logic               neg_q, sine_sel_q;
  logic [OUT_W-1:0]   samp_q, sample_q, sine_val;

  assign ph_top = (LUT_AW+2)'((acc_q + off_s1_q) >> (ACC_W - 2 - LUT_AW));

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '0;
      addr_q     <= '0;
      neg_q      <= 1'b0;
      sine_sel_q <= 1'b0;
      sample_q   <= '0;
    end else begin
      samp_q     <= wave_d;
      addr_q     <= ph_top[LUT_AW] ? ~ph_top[LUT_AW-1:0] : ph_top[LUT_AW-1:0];
      neg_q      <= ph_top[LUT_AW+1];
      sine_sel_q <= en_s1_q && (mode_s1_q == MODE_SINE);
      sample_q   <= sine_sel_q ? sine_val : samp_q;
    end
  end

  // Lower half mirrors the upper half about midscale: mid-1-amp == {0, ~amp}.
  assign sine_val = neg_q ? {1'b0, ~rom[addr_q]} : {1'b1, rom[addr_q]};
  assign sample_o = sample_q;
`else
  logic [OUT_W-1:0] sample_q;

  always_ff @(posedge clk) begin
    if (rst) sample_q <= '0;
    else     sample_q <= wave_d;
  end

  assign sample_o = sample_q;
`endif

endmodule

// File: rtl/dds_bank.sv
// NCH-channel DDS bank with shadowed registers and a common commit/sync.
// Optional sine ROM mode is enabled by defining DDS_BANK_SINE_LUT_EN.
module dds_bank #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned LUT_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(NCH)+1:0]   wr_addr,
  input  logic [ACC_W-1:0]         wr_data,
  input  logic                     commit,
  input  logic                     sync,
  output logic [NCH*OUT_W-1:0]     out,
  output logic                     out_valid
);
  import dds_pkg::*;

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("dds_bank: NCH must be in 1..16");
  end

  logic [CH_W-1:0] wr_ch;
  logic [1:0]      wr_reg;

  assign wr_reg = wr_addr[1:0];

  if (NCH > 1) begin : g_ch_multi
    assign wr_ch = wr_addr[CH_W+1:2];
  end else begin : g_ch_single
    assign wr_ch = '0;
  end

  // Channel indices >= NCH match no instance, so such writes fall away.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    dds_channel #(
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .LUT_AW (LUT_AW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en && (wr_ch == CH_W'(k))),
      .wr_reg_i  (wr_reg),
      .wr_data_i (wr_data),
      .commit_i  (commit),
      .sync_i    (sync),
      .sample_o  (out[k*OUT_W +: OUT_W])
    );
  end

  logic [LAT-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = {vld_q[LAT-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign out_valid = vld_q[LAT-1];

endmodule

// File: tb/tb_dds_bank.sv
// Directed self-checking bench for dds_bank (default build, two channels, 8-bit samples).
module tb_dds_bank;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = $clog2(NCH) + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          commit;
  logic          sync;
  logic [15:0]   out;
  logic          out_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dds_bank #(
    .NCH    (NCH),
    .ACC_W  (32),
    .OUT_W  (8),
    .LUT_AW (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit    (commit),
    .sync      (sync),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned ch, input int unsigned rg, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = {ch[0], rg[1:0]};
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic [31:0] tri_exp(input int unsigned ph);
    return (ph < 128) ? 2 * ph : 255 - 2 * (ph - 128);
  endfunction

  function automatic logic [31:0] sq_exp(input int unsigned ph);
    return (ph >= 128) ? 32'd255 : 32'd0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned e0;
    logic [7:0]  lead;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; sync = 1'b0;
    repeat (3) tick();
    check("rst_out", 32'(out), 0);
    check("rst_valid", 32'(out_valid), 0);
    rst = 1'b0;
    tick(); check("valid_lat1", 32'(out_valid), 0);
    tick(); check("valid_lat2", 32'(out_valid), 1);

    // saw ramp at one code per clock
    wr(0, 0, 32'h0100_0000);
    wr(0, 2, 32'h1);
    commit = 1'b1; tick(); commit = 1'b0;
    tick(); check("t1_pre", 32'(out[7:0]), 0);
    tick(); check("t1_first", 32'(out[7:0]), 1);
    e0 = 1;
    for (int i = 0; i < 300; i++) begin
      tick(); e0 = (e0 + 1) % 256;
      check("t1_ramp", 32'(out[7:0]), e0);
    end
    check("t1_valid", 32'(out_valid), 1);

    // shadow write has no effect until commit; new rate appears at t+3
    wr(0, 0, 32'h0300_0000);
    e0 = (e0 + 1) % 256; check("t2_write", 32'(out[7:0]), e0);
    for (int i = 0; i < 20; i++) begin
      tick(); e0 = (e0 + 1) % 256;
      check("t2_hold", 32'(out[7:0]), e0);
    end
    commit = 1'b1; tick(); commit = 1'b0;
    e0 = (e0 + 1) % 256; check("t2_c1", 32'(out[7:0]), e0);
    tick(); e0 = (e0 + 1) % 256; check("t2_c2", 32'(out[7:0]), e0);
    tick(); e0 = (e0 + 3) % 256; check("t2_c3", 32'(out[7:0]), e0);
    for (int i = 0; i < 10; i++) begin
      tick(); e0 = (e0 + 3) % 256;
      check("t2_new", 32'(out[7:0]), e0);
    end

    // phase offset: ch1 leads ch0 by 64 codes after sync
    wr(0, 0, 32'h0200_0000);
    wr(1, 0, 32'h0200_0000);
    wr(1, 1, 32'h4000_0000);
    wr(1, 2, 32'h1);
    commit = 1'b1; tick(); commit = 1'b0;
    sync = 1'b1; tick(); sync = 1'b0;
    tick();
    check("t3_ch0_start", 32'(out[7:0]), 0);
    check("t3_ch1_start", 32'(out[15:8]), 64);
    e0 = 0;
    for (int i = 0; i < 200; i++) begin
      tick(); e0 = (e0 + 2) % 256;
      check("t3_ch0", 32'(out[7:0]), e0);
      lead = out[15:8] - out[7:0];
      check("t3_lead", 32'(lead), 64);
    end

    // triangle, with commit and sync in the same cycle
    wr(0, 0, 32'h0100_0000);
    wr(0, 2, 32'h5);
    commit = 1'b1; sync = 1'b1; tick(); commit = 1'b0; sync = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      check("t4_tri", 32'(out[7:0]), tri_exp(k % 256));
    end

    // commit together with a write takes the pre-write shadow value
    wr(0, 0, 32'h0200_0000);
    wr(0, 2, 32'h1);
    wr_en = 1'b1; wr_addr = {1'b0, 2'd0}; wr_data = 32'h0400_0000;
    commit = 1'b1; sync = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0; sync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); check("t5_old", 32'(out[7:0]), 2 * k);
    end
    commit = 1'b1; sync = 1'b1; tick(); commit = 1'b0; sync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); check("t5_new", 32'(out[7:0]), 4 * k);
    end

    // mid-run reset flushes pipeline and loses shadows
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_out", 32'(out), 0);
    check("t6_valid0", 32'(out_valid), 0);
    tick(); check("t6_valid1", 32'(out_valid), 0);
    tick(); check("t6_valid2", 32'(out_valid), 1);
    commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); check("t6_idle", 32'(out), 0);
    end

    // saw + square, reserved register ignored, then disable ch0
    wr(0, 0, 32'h0100_0000);
    wr(0, 2, 32'h1);
    wr(1, 0, 32'h0100_0000);
    wr(1, 2, 32'h3);
    wr(0, 3, 32'hFFFF_FFFF);
    commit = 1'b1; sync = 1'b1; tick(); commit = 1'b0; sync = 1'b0;
    for (int k = 0; k < 260; k++) begin
      tick();
      check("t7_saw", 32'(out[7:0]), k % 256);
      check("t7_sq", 32'(out[15:8]), sq_exp(k % 256));
    end
    wr(0, 2, 32'h0);
    check("t7_dis_w", 32'(out[7:0]), 260 % 256);
    commit = 1'b1; tick(); commit = 1'b0;
    check("t7_dis_c1", 32'(out[7:0]), 261 % 256);
    tick(); check("t7_dis_c2", 32'(out[7:0]), 262 % 256);
    tick(); check("t7_dis_c3", 32'(out[7:0]), 0);
    check("t7_sq_c3", 32'(out[15:8]), sq_exp(263 % 256));
    for (int k = 264; k < 270; k++) begin
      tick();
      check("t7_off", 32'(out[7:0]), 0);
      check("t7_sq_on", 32'(out[15:8]), sq_exp(k % 256));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
